// File: rtl/turfio_clk_ctrl.sv
// Bring-up and lock supervision for the TURFIO bank 67/68 interface MMCMs.
// Each bank pulses RST, waits for LOCKED, qualifies it, then reports READY.
`timescale 1ns/1ps
module turfio_clk_ctrl #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        enable_i,
    input  logic [1:0]  reset_req_i,
    input  logic [1:0]  locked_i,
    output logic [1:0]  mmcm_rst_o,
    output logic [1:0]  ready_o,
    output logic        all_ready_o,
    output logic [15:0] lock_loss_cnt_o,
    output logic [15:0] timeout_cnt_o,
    output logic [5:0]  state_o
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PEND  = 3'd1,
        S_RST   = 3'd2,
        S_WAIT  = 3'd3,
        S_STAB  = 3'd4,
        S_READY = 3'd5
    } state_t;

    localparam logic [19:0] RST_LAST  = 20'(RST_CYCLES - 1);
    localparam logic [19:0] WAIT_LAST = 20'(LOCK_TIMEOUT - 1);
    localparam logic [19:0] STAB_LAST = 20'(STABLE_CYCLES);

    state_t      r_state     [2];
    logic [19:0] r_timer     [2];
    logic [7:0]  r_lock_loss [2];
    logic [7:0]  r_timeout   [2];
    logic [1:0]  r_lock_meta;
    logic [1:0]  r_lock_s;
    logic [1:0]  r_mmcm_rst;
    logic [1:0]  r_ready;
    logic        r_all_ready;

    state_t      w_next [2];
    logic [1:0]  w_rst_busy;
    logic [1:0]  w_grant;
    logic [1:0]  w_timeout_inc;
    logic [1:0]  w_lock_loss_inc;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_lock_meta <= '0;
            r_lock_s    <= '0;
        end else begin
            r_lock_meta <= locked_i;
            r_lock_s    <= r_lock_meta;
        end
    end

    // A bank "holds" RST only if it will still be in RST after this edge, so the
    // hand-off from one bank to the other happens on the same edge without overlap.
    always_comb begin
        w_rst_busy = '0;
        w_grant    = '0;
        for (int b = 0; b < 2; b++) begin
            w_rst_busy[b] = enable_i && (r_state[b] == S_RST) && (r_timer[b] != RST_LAST);
        end
        w_grant[0] = (r_state[0] == S_PEND) && !w_rst_busy[1];
        w_grant[1] = (r_state[1] == S_PEND) && !w_rst_busy[0] && !w_grant[0];
    end

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_timeout_inc   = '0;
        w_lock_loss_inc = '0;
        for (int b = 0; b < 2; b++) begin
            w_next[b] = r_state[b];
            if (!enable_i) begin
                w_next[b] = S_IDLE;
            end else begin
                case (r_state[b])
                    S_IDLE:  w_next[b] = S_PEND;
                    S_PEND:  if (w_grant[b]) w_next[b] = S_RST;
                    S_RST:   if (r_timer[b] == RST_LAST) w_next[b] = S_WAIT;
                    S_WAIT: begin
                        if (reset_req_i[b]) begin
                            w_next[b] = S_PEND;
                        end else if (r_lock_s[b]) begin
                            w_next[b] = S_STAB;
                        end else if (r_timer[b] == WAIT_LAST) begin
                            w_next[b]        = S_PEND;
                            w_timeout_inc[b] = 1'b1;
                        end
                    end
                    S_STAB: begin
                        if (reset_req_i[b])             w_next[b] = S_PEND;
                        else if (!r_lock_s[b])          w_next[b] = S_WAIT;
                        else if (r_timer[b] == STAB_LAST) w_next[b] = S_READY;
                    end
                    S_READY: begin
                        if (reset_req_i[b]) begin
                            w_next[b] = S_PEND;
                        end else if (!r_lock_s[b]) begin
                            w_next[b]          = S_PEND;
                            w_lock_loss_inc[b] = 1'b1;
                        end
                    end
                    default: w_next[b] = S_IDLE;
                endcase
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the per-bank
    // arrays are a handful of flops, so they are reset along with everything else.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int b = 0; b < 2; b++) begin
                r_state[b]     <= S_IDLE;
                r_timer[b]     <= '0;
                r_lock_loss[b] <= '0;
                r_timeout[b]   <= '0;
            end
            r_mmcm_rst  <= 2'b11;
            r_ready     <= '0;
            r_all_ready <= 1'b0;
        end else begin
            for (int b = 0; b < 2; b++) begin
                r_state[b] <= w_next[b];
                if (w_next[b] != r_state[b]) begin
                    r_timer[b] <= '0;
                end else if (r_state[b] inside {S_RST, S_WAIT, S_STAB}) begin
                    r_timer[b] <= r_timer[b] + 20'd1;
                end
                if (w_timeout_inc[b] && (r_timeout[b] != 8'hFF)) begin
                    r_timeout[b] <= r_timeout[b] + 8'd1;
                end
                if (w_lock_loss_inc[b] && (r_lock_loss[b] != 8'hFF)) begin
                    r_lock_loss[b] <= r_lock_loss[b] + 8'd1;
                end
                r_mmcm_rst[b] <= (w_next[b] inside {S_IDLE, S_PEND, S_RST});
                r_ready[b]    <= (w_next[b] == S_READY);
            end
            r_all_ready <= (w_next[0] == S_READY) && (w_next[1] == S_READY);
        end
    end

    assign mmcm_rst_o      = r_mmcm_rst;
    assign ready_o         = r_ready;
    assign all_ready_o     = r_all_ready;
    assign lock_loss_cnt_o = {r_lock_loss[1], r_lock_loss[0]};
    assign timeout_cnt_o   = {r_timeout[1], r_timeout[0]};
    assign state_o         = {r_state[1], r_state[0]};

endmodule

// File: doc/turfio_clk_ctrl.md
# turfio_clk_ctrl

Bring-up and supervision controller for the two TURFIO interface MMCMs (bank 67 and bank 68). It drives each MMCM's RST, waits for LOCKED with a timeout, and qualifies lock over a stability window before declaring the interface clocks ready. It also re-sequences a bank automatically on loss of lock or on software request. Reset windows are arbitrated so the two MMCMs are never in their RST pulse at the same time. The block runs on the free-running 125 MHz sysclk and sits between the register interface and the interface-clock MMCM wrapper.

## Interface
- RST_CYCLES, 16: cycles each MMCM RST pulse is held in state RST (≥2).
- LOCK_TIMEOUT, 65536: cycles allowed in WAIT before a timeout (≥4, ≤2^20).
- STABLE_CYCLES, 1024: cycles the synchronized lock must stay high before READY (≥1, ≤2^16).

- clk_i  in  1  free-running sysclk.
- rst_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  level; high runs sequencing, low forces both banks to IDLE.
- reset_req_i  in  2  one-cycle request per bank ([0]=67, [1]=68) to re-sequence.
- locked_i  in  2  raw MMCM LOCKED; asynchronous, double-flop synchronized internally.
- mmcm_rst_o  out  2  MMCM RST per bank, registered.
- ready_o  out  2  bank clock qualified, registered.
- all_ready_o  out  1  &ready_o, registered.
- lock_loss_cnt_o  out  16  {bank68[7:0], bank67[7:0]}; saturating lock-loss counts.
- timeout_cnt_o  out  16  {bank68[7:0], bank67[7:0]}; saturating lock-timeout counts.
- state_o  out  6  {bank68[2:0], bank67[2:0]}; per-bank state encoding.

## Operation
- Per-bank FSM with encodings IDLE=0, PEND=1, RST=2, WAIT=3, STAB=4, READY=5. Codes 6 and 7 are illegal and recover to IDLE.
- IDLE: mmcm_rst=1. If enable_i is high, go to PEND.
- PEND: mmcm_rst=1. Go to RST when granted.
- RST: mmcm_rst=1 for exactly RST_CYCLES cycles, then go to WAIT with the timer cleared.
- WAIT: mmcm_rst=0.
  - If lock_s=1, go to STAB.
  - If the timer reaches LOCK_TIMEOUT-1 with no lock, increment timeout_cnt and go to PEND.
- STAB: mmcm_rst=0.
  - If lock_s drops, go to WAIT with the timer cleared (no count).
  - After STABLE_CYCLES consecutive cycles with lock_s=1, go to READY.
- READY: ready=1.
  - If lock_s=0, increment lock_loss_cnt and go to PEND.
  - If reset_req_i[b] is high, go to PEND with no count.
- Priority in every state: enable_i low (go to IDLE) > reset_req_i > lock or timer events.
- reset_req_i in IDLE, PEND or RST is ignored. In WAIT or STAB it goes to PEND.
- Arbiter: a bank in PEND is granted only if the other bank is not in RST and is not being granted on the same edge. On a tie, bank 67 wins; bank 68 waits in PEND.
- Counters are 8-bit, saturate at 255, and are cleared only by rst_n_i.
- Each bank has one shared 20-bit timer, reused as the RST, WAIT and STAB counter and cleared on every state entry.

## Timing
- Reset values:
  - mmcm_rst_o=2'b11 (MMCMs held in reset).
  - ready_o=0, all_ready_o=0.
  - counters=0.
  - state_o=0.
  - lock synchronizers=0.
- Outputs are registered from the next state, so every output changes on the same edge that state_o does.
- lock_s lags locked_i by 2 clk_i edges.
- Startup (both banks responsive, enable_i sampled high at edge 0):
  - Both banks enter PEND at edge 1.
  - Bank 67 enters RST at edge 2; mmcm_rst_o[0] falls at edge 2+RST_CYCLES.
  - Bank 68 enters RST at edge 2+RST_CYCLES; mmcm_rst_o[1] falls at edge 2+2·RST_CYCLES.
- If locked_i[b] is first sampled high at edge t and stays high, ready_o[b] rises at edge t+3+STABLE_CYCLES.
- all_ready_o rises on the same edge that the second ready_o rises.
- Loss of lock in READY: lock_s falls at edge u, and on edge u+1 ready_o[b]=0, mmcm_rst_o[b]=1 and the counter increments. An ungranted bank stays in PEND with mmcm_rst=1.
- rst_n_i asserted mid-operation forces all outputs to their reset values immediately (asynchronously). Deassertion is synchronized to clk_i by the parent.

## Test plan
Bench parameters: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8. The MMCM model raises locked_i 10 cycles after RST falls.

1. Startup: enable_i rises at edge 0.
   - mmcm_rst_o[0] falls at edge 6 and mmcm_rst_o[1] at edge 10, with no overlap of the RST states.
   - ready_o[0] rises at edge 27 and ready_o[1] at edge 31; all_ready_o rises at edge 31.
2. Timeout: locked_i[1] held 0.
   - Bank 68 cycles WAIT→PEND→RST.
   - timeout_cnt_o[15:8] increments once per 32+4+1 cycles and saturates at 255.
   - Bank 67 reaches READY unaffected.
3. Lock loss: locked_i[0] dropped for 5 cycles while both banks are READY.
   - lock_loss_cnt_o[7:0]=1.
   - Bank 67 re-sequences and ready_o[0] returns.
   - ready_o[1] stays 1 throughout.
4. Simultaneous requests: reset_req_i=2'b11 while both banks are READY.
   - Bank 67 is in RST first; bank 68 enters RST exactly 4 cycles later.
   - Both counters stay 0.
5. Lock chatter in STAB: locked_i[0] drops for 1 cycle.
   - Bank 67 returns to WAIT and the timer restarts.
   - No counter changes; ready_o rises 3+8 edges after lock is sampled high again.
6. Disable and reset:
   - enable_i low mid-STAB: the next edge gives state_o=0 and mmcm_rst_o=2'b11.
   - rst_n_i low in READY: outputs take reset values with no clock edge, and the counters are cleared.
